// File: rtl/mul_err_monitor_pkg.sv
// Shared definitions for the multiplier error monitor.
//   - Operand and product widths of the multiplier under observation.
//   - Number of cycles spent in the shift-add multiply phase.
//   - FSM state type used by the monitor top level.
package mul_err_pkg;

  localparam int OP_W       = 16;
  localparam int PROD_W     = 32;
  localparam int MUL_CYCLES = 16;
  localparam int MUL_CNT_W  = $clog2(MUL_CYCLES);

  typedef logic [OP_W-1:0]   op_t;
  typedef logic [PROD_W-1:0] prod_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_CMP  = 2'd2,
    ST_ACC  = 2'd3
  } state_e;

endpackage

// File: rtl/mul_err_monitor_if.sv
// Sample channel into the error monitor.
//   in_valid  : producer offers a sample
//   in_ready  : monitor can accept a sample
//   in_a/in_b : multiplier operands
//   in_prod   : approximate product under test
// master = sample producer, slave = monitor.
interface mul_err_monitor_if;

  logic                          in_valid;
  logic                          in_ready;
  logic [mul_err_pkg::OP_W-1:0]   in_a;
  logic [mul_err_pkg::OP_W-1:0]   in_b;
  logic [mul_err_pkg::PROD_W-1:0] in_prod;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_prod,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_prod,
    output in_ready
  );

endinterface

// File: rtl/mul_err_monitor_seq_mul.sv
// Radix-2 shift-add unsigned multiplier, one bit of b per cycle, LSB first.
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   start_i   : load a_i/b_i and begin (ignored unless pulsed by the owner)
//   a_i, b_i  : operands
//   done_o    : high during the cycle whose closing edge performs the last step
//   product_o : accumulated product, final after the edge on which done_o is high
module seq_mul_16x16
  import mul_err_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  start_i,
  input  op_t   a_i,
  input  op_t   b_i,
  output logic  done_o,
  output prod_t product_o
);

  localparam logic [MUL_CNT_W-1:0] LAST_STEP = MUL_CNT_W'(MUL_CYCLES - 1);

  logic                 run_q;
  logic [MUL_CNT_W-1:0] step_q;
  prod_t                mcand_q;
  op_t                  mplier_q;
  prod_t                acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      step_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      run_q    <= 1'b1;
      step_q   <= '0;
      mcand_q  <= {{(PROD_W-OP_W){1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      step_q   <= step_q + 1'b1;
      if (step_q == LAST_STEP) begin
        run_q <= 1'b0;
      end
    end
  end

  // Combinational so the owner's FSM can leave its multiply state on the
  // same edge that completes the final accumulation step.
  assign done_o    = run_q && (step_q == LAST_STEP);
  assign product_o = acc_q;

endmodule

// File: rtl/mul_err_monitor.sv
// Error monitor for an approximate 16x16 multiplier.
// Each accepted sample is re-multiplied exactly, compared with the supplied
// approximate product, and folded into running statistics.
//   clk, rst_n        : clock, asynchronous active-low reset
//   clear             : synchronous clear of sum_err/max_err/count
//   smp (slave)       : sample channel (in_valid/in_ready/in_a/in_b/in_prod)
//   err_valid         : one-cycle pulse, err_abs/err_sign belong to latest sample
//   err_abs, err_sign : |exact - in_prod|, 1 when in_prod < exact
//   sum_err, max_err  : saturating running sum and maximum of err_abs
//   count             : saturating sample count
//   busy              : high whenever not IDLE
module mul_err_monitor
  import mul_err_pkg::*;
#(
  parameter int SUM_W = 48,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  mul_err_monitor_if.slave    smp,
  output logic                err_valid,
  output prod_t               err_abs,
  output logic                err_sign,
  output logic [SUM_W-1:0]    sum_err,
  output prod_t               max_err,
  output logic [CNT_W-1:0]    count,
  output logic                busy
);

  state_e             state_q, state_d;
  prod_t              prod_cap_q, prod_cap_d;
  prod_t              err_abs_q, err_abs_d;
  logic               err_sign_q, err_sign_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  prod_t              max_q, max_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic               mul_done;
  prod_t              exact;
  logic [SUM_W:0]     sum_wide;

  assign accept = (state_q == ST_IDLE) && smp.in_valid;

  seq_mul_16x16 u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (accept),
    .a_i       (smp.in_a),
    .b_i       (smp.in_b),
    .done_o    (mul_done),
    .product_o (exact)
  );

  // One extra bit catches the carry out so the sum can clamp instead of wrap.
  assign sum_wide = {1'b0, sum_q} + {{(SUM_W-PROD_W+1){1'b0}}, err_abs_q};

  always_comb begin
    state_d    = state_q;
    prod_cap_d = prod_cap_q;
    err_abs_d  = err_abs_q;
    err_sign_d = err_sign_q;
    sum_d      = sum_q;
    max_d      = max_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (smp.in_valid) begin
          prod_cap_d = smp.in_prod;
          state_d    = ST_MUL;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        if (exact > prod_cap_q) begin
          err_abs_d  = exact - prod_cap_q;
          err_sign_d = 1'b1;
        end else begin
          err_abs_d  = prod_cap_q - exact;
          err_sign_d = 1'b0;
        end
        state_d = ST_ACC;
      end
      ST_ACC: begin
        sum_d = sum_wide[SUM_W] ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
        if (err_abs_q > max_q) begin
          max_d = err_abs_q;
        end
        if (!(&cnt_q)) begin
          cnt_d = cnt_q + 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear overrides any same-cycle accumulation; the in-flight result
    // (err_abs/err_sign) is deliberately left alone.
    if (clear) begin
      sum_d = '0;
      max_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      prod_cap_q <= '0;
      err_abs_q  <= '0;
      err_sign_q <= 1'b0;
      sum_q      <= '0;
      max_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      prod_cap_q <= prod_cap_d;
      err_abs_q  <= err_abs_d;
      err_sign_q <= err_sign_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      cnt_q      <= cnt_d;
    end
  end

  assign smp.in_ready = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign err_valid    = (state_q == ST_ACC);
  assign err_abs      = err_abs_q;
  assign err_sign     = err_sign_q;
  assign sum_err      = sum_q;
  assign max_err      = max_q;
  assign count        = cnt_q;

endmodule

// File: tb/tb_mul_err_monitor.sv
module tb_mul_err_monitor;
  import mul_err_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mul_err_monitor_if u_if ();
  mul_err_monitor_if u_if2 ();
  assign u_if2.in_valid = u_if.in_valid;
  assign u_if2.in_a     = u_if.in_a;
  assign u_if2.in_b     = u_if.in_b;
  assign u_if2.in_prod  = u_if.in_prod;

  logic        err_valid, err_sign, busy;
  logic [31:0] err_abs, max_err;
  logic [47:0] sum_err;
  logic [15:0] count;
  logic        err_valid2, err_sign2, busy2;
  logic [31:0] err_abs2, max_err2;
  logic [32:0] sum_err2;
  logic [1:0]  count2;

  mul_err_monitor dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .smp(u_if),
    .err_valid(err_valid), .err_abs(err_abs), .err_sign(err_sign),
    .sum_err(sum_err), .max_err(max_err), .count(count), .busy(busy)
  );

  // Narrow instance in lockstep: exercises count and sum saturation.
  mul_err_monitor #(.SUM_W(33), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .smp(u_if2),
    .err_valid(err_valid2), .err_abs(err_abs2), .err_sign(err_sign2),
    .sum_err(sum_err2), .max_err(max_err2), .count(count2), .busy(busy2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] abs_v;
    logic        sign_v;
    logic [47:0] sum_v;
    logic [31:0] max_v;
    logic [15:0] cnt_v;
    logic [32:0] sum2_v;
    logic [1:0]  cnt2_v;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_busy = 1'b0;

  logic [47:0] m_sum = '0;
  logic [31:0] m_max = '0;
  logic [15:0] m_cnt = '0;
  logic [32:0] m_sum2 = '0;
  logic [1:0]  m_cnt2 = '0;

  task automatic model_reset();
    m_sum = '0; m_max = '0; m_cnt = '0; m_sum2 = '0; m_cnt2 = '0;
  endtask

  task automatic push_exp(input logic [31:0] abs_v, input logic sign_v,
                          input int acc_cyc, input bit clr);
    exp_t e;
    logic [63:0] t;
    if (clr) begin
      model_reset();
    end else begin
      t = {16'h0, m_sum} + {32'h0, abs_v};
      m_sum = (t > 64'hFFFF_FFFF_FFFF) ? 48'hFFFF_FFFF_FFFF : t[47:0];
      t = {31'h0, m_sum2} + {32'h0, abs_v};
      m_sum2 = (t > 64'h1_FFFF_FFFF) ? 33'h1_FFFF_FFFF : t[32:0];
      if (abs_v > m_max) m_max = abs_v;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
    end
    e.abs_v = abs_v; e.sign_v = sign_v;
    e.sum_v = m_sum; e.max_v = m_max; e.cnt_v = m_cnt;
    e.sum2_v = m_sum2; e.cnt2_v = m_cnt2; e.acc_cyc = acc_cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!u_if.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      failures++;
      $display("FAIL wait_ready timeout");
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Issue one sample; expected err values are hand-computed by the caller.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [31:0] p,
                      input logic [31:0] e_abs, input logic e_sign, input bit clr);
    int acc;
    wait_ready();
    u_if.in_valid = 1'b1; u_if.in_a = a; u_if.in_b = b; u_if.in_prod = p;
    @(posedge clk); #1;
    acc = cyc;
    u_if.in_valid = 1'b0;
    push_exp(e_abs, e_sign, acc, clr);
    if (clr) begin
      repeat (17) @(posedge clk);
      #1 clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (err_valid) begin
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
          failures++; checks++;
          $display("FAIL unexpected_err_valid err_abs=%0h required=none", err_abs);
          @(posedge clk); #1;
        end else begin
          e = exp_q.pop_front();
          chk("err_abs", 64'(err_abs), 64'(e.abs_v));
          chk("err_sign", 64'(err_sign), 64'(e.sign_v));
          chk("latency", 64'(cyc), 64'(e.acc_cyc + 17));
          chk("err_valid_lockstep", 64'(err_valid2), 64'd1);
          @(posedge clk); #1;
          chk("err_valid_pulse", 64'(err_valid), 64'd0);
          chk("err_abs_hold", 64'(err_abs), 64'(e.abs_v));
          chk("sum_err", 64'(sum_err), 64'(e.sum_v));
          chk("max_err", 64'(max_err), 64'(e.max_v));
          chk("count", 64'(count), 64'(e.cnt_v));
          chk("sum_err_sat33", 64'(sum_err2), 64'(e.sum2_v));
          chk("count_sat2", 64'(count2), 64'(e.cnt2_v));
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Accepted samples of the continuous-valid burst (cycles 0, 19, 38).
  logic [31:0] burst_prod [3] = '{32'd0, 32'd1, 32'd2};
  logic [31:0] burst_abs  [3] = '{32'hFFFE_0001, 32'hFFFE_0000, 32'hFFFD_FFFF};

  initial begin
    int acc;
    u_if.in_valid = 1'b0; u_if.in_a = '0; u_if.in_b = '0; u_if.in_prod = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(u_if.in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err_valid", 64'(err_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_sum", 64'(sum_err), 64'd0);
    chk("rst_max", 64'(max_err), 64'd0);

    // Exact product, then a low guess and a high guess.
    send(16'd1024, 16'd2134, 32'd2185216, 32'd0,   1'b0, 1'b0);
    send(16'd1025, 16'd2134, 32'd2187000, 32'd350, 1'b1, 1'b0);
    send(16'd2,    16'd3,    32'd10,      32'd4,   1'b0, 1'b0);
    // Clear coinciding with the ACC edge: sample not counted.
    send(16'd5,    16'd7,    32'd30,      32'd5,   1'b1, 1'b1);
    wait_drain();

    // in_valid held high with data changing every cycle.
    wait_ready();
    for (int k = 0; k < 57; k++) begin
      u_if.in_valid = 1'b1;
      if (k % 19 == 0) begin
        u_if.in_a = 16'hFFFF; u_if.in_b = 16'hFFFF; u_if.in_prod = burst_prod[k / 19];
      end else begin
        u_if.in_a = 16'(k); u_if.in_b = 16'(k + 3); u_if.in_prod = 32'(k);
      end
      @(posedge clk); #1;
      if (k % 19 == 0) begin
        acc = cyc;
        push_exp(burst_abs[k / 19], 1'b1, acc, 1'b0);
      end
      @(negedge clk);
    end
    u_if.in_valid = 1'b0;
    wait_drain();

    // Reset during cycle 8 of MUL aborts the sample.
    wait_ready();
    u_if.in_valid = 1'b1; u_if.in_a = 16'd1234; u_if.in_b = 16'd5678; u_if.in_prod = 32'd0;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_in_ready", 64'(u_if.in_ready), 64'd1);
    chk("mid_rst_err_valid", 64'(err_valid), 64'd0);
    chk("mid_rst_err_abs", 64'(err_abs), 64'd0);
    chk("mid_rst_err_sign", 64'(err_sign), 64'd0);
    chk("mid_rst_sum", 64'(sum_err), 64'd0);
    chk("mid_rst_max", 64'(max_err), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Four samples after reset: narrow counter sticks at 3.
    send(16'd100,   16'd200, 32'd20000, 32'd0,   1'b0, 1'b0);
    send(16'd300,   16'd3,   32'd800,   32'd100, 1'b1, 1'b0);
    send(16'd12,    16'd12,  32'd150,   32'd6,   1'b0, 1'b0);
    send(16'd65535, 16'd1,   32'd65535, 32'd0,   1'b0, 1'b0);
    wait_drain();
    chk("final_count2", 64'(count2), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
